// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin arbiter granting one of 8 requesters through a 3-to-8 decoder
// Optional tenure timeout enabled by defining TIMEOUT_EN.

module decoder_3x8 (
    input  logic [2:0] i_in,
    input  logic       i_en,
    output logic [7:0] o_out
);
    always_comb begin
        o_out = 8'h00;
        if (i_en) begin
            o_out[i_in] = 1'b1;
        end
    end
endmodule

module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_rel,
    output logic [2:0] o_gnt_idx,
    output logic       o_gnt_en,
    output logic [7:0] o_gnt_onehot,
    output logic       o_busy,
    output logic       o_timeout
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_gnt_idx;
    logic [2:0] w_gnt_idx_nxt;
    logic       r_gnt_en;
    logic       w_gnt_en_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic       w_pick_valid;
    logic [2:0] w_pick_idx;
    logic       w_owner_done;
    logic       w_expire;

    // Scan from the highest offset down so the offset closest to r_ptr wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (i_req[r_ptr + 3'(i)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = r_ptr + 3'(i);
            end
        end
    end

`ifdef TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ST_IDLE && w_pick_valid) begin
            w_cnt_nxt = '0;
        end else if (r_state == ST_GRANT && r_cnt != HOLD_SAT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign w_expire = (r_state == ST_GRANT) && (r_cnt == HOLD_LAST);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (HOLD_MAX > CNT_W);
    assign w_expire     = 1'b0;
`endif

    assign w_owner_done = i_rel || !i_req[r_gnt_idx];

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_en_nxt  = r_gnt_en;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_idx_nxt = w_pick_idx;
                    w_gnt_en_nxt  = 1'b1;
                    w_state_nxt   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A normal release takes precedence; timeout only flags a forced revoke.
                if (w_owner_done || w_expire) begin
                    w_gnt_en_nxt  = 1'b0;
                    w_ptr_nxt     = r_gnt_idx + 3'd1;
                    w_timeout_nxt = w_expire && !w_owner_done;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_en_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_gnt_idx <= 3'd0;
            r_gnt_en  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt_en  <= w_gnt_en_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    decoder_3x8 u_dec (
        .i_in  (r_gnt_idx),
        .i_en  (r_gnt_en),
        .o_out (o_gnt_onehot)
    );

    assign o_gnt_idx = r_gnt_idx;
    assign o_gnt_en  = r_gnt_en;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_timeout = r_timeout;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - directed vector bench for decoder_rr_arbiter

module tb_decoder_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic [7:0] gnt_onehot;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    decoder_rr_arbiter #(.HOLD_MAX(16), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_rel        (rel),
        .o_gnt_idx    (gnt_idx),
        .o_gnt_en     (gnt_en),
        .o_gnt_onehot (gnt_onehot),
        .o_busy       (busy),
        .o_timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rel;
        logic       en;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[80];
    int   nvec = 0;

    function automatic void add(input logic r, input logic [7:0] q, input logic l,
                                input logic e, input logic [2:0] x, input logic b);
        vecs[nvec].rst  = r;
        vecs[nvec].req  = q;
        vecs[nvec].rel  = l;
        vecs[nvec].en   = e;
        vecs[nvec].idx  = x;
        vecs[nvec].oh   = e ? (8'h01 << x) : 8'h00;
        vecs[nvec].busy = b;
        vecs[nvec].to   = 1'b0;
        nvec++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        int n;
        int drops;
        int to_seen;

        // Reset held with all requests pending, then the first grant.
        add(1, 8'hFF, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 0, 0, 0);
        add(0, 8'hFF, 0, 1, 0, 1);
        // Full rotation 1..7,0 with release each tenure.
        prev = 0;
        for (int k = 1; k <= 8; k++) begin
            add(0, 8'hFF, 1, 0, 3'(prev), 1);
            add(0, 8'hFF, 0, 0, 3'(prev), 0);
            add(0, 8'hFF, 0, 1, 3'(k % 8), 1);
            prev = k % 8;
        end
        // Single requester 5, then idle with no requests and a stray rel.
        add(0, 8'h20, 1, 0, 0, 1);
        add(0, 8'h20, 0, 0, 0, 0);
        add(0, 8'h20, 0, 1, 5, 1);
        add(0, 8'h20, 1, 0, 5, 1);
        add(0, 8'h00, 0, 0, 5, 0);
        add(0, 8'h00, 0, 0, 5, 0);
        add(0, 8'h00, 1, 0, 5, 0);
        // Serve 6 so the pointer sits at 7, then wrap to 0 and 1.
        add(0, 8'h40, 0, 1, 6, 1);
        add(0, 8'h40, 1, 0, 6, 1);
        add(0, 8'h03, 0, 0, 6, 0);
        add(0, 8'h03, 0, 1, 0, 1);
        add(0, 8'h03, 1, 0, 0, 1);
        add(0, 8'h03, 0, 0, 0, 0);
        add(0, 8'h03, 0, 1, 1, 1);
        add(0, 8'h0A, 0, 1, 1, 1);
        // Owner drops its request without rel.
        add(0, 8'h08, 0, 0, 1, 1);
        add(0, 8'h08, 0, 0, 1, 0);
        add(0, 8'h08, 0, 1, 3, 1);
        add(0, 8'h09, 0, 1, 3, 1);
        add(0, 8'h01, 0, 0, 3, 1);
        add(0, 8'h11, 0, 0, 3, 0);
        add(0, 8'h11, 0, 1, 4, 1);
        add(0, 8'h11, 1, 0, 4, 1);
        add(0, 8'h11, 0, 0, 4, 0);
        add(0, 8'h11, 0, 1, 0, 1);
        // Reset mid-grant returns the pointer to 0: 4 wins over 5.
        add(1, 8'h30, 0, 0, 0, 0);
        add(0, 8'h30, 0, 1, 4, 1);

        for (int i = 0; i < nvec; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            rel = vecs[i].rel;
            step();
            check($sformatf("vec%0d {en,idx,oh,busy,to}", i),
                  {19'd0, gnt_en, gnt_idx, gnt_onehot, busy, timeout},
                  {19'd0, vecs[i].en, vecs[i].idx, vecs[i].oh, vecs[i].busy, vecs[i].to});
        end

        // Asynchronous reset drops the grant without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst gnt_en", gnt_en, 0);
        check("async_rst onehot", gnt_onehot, 0);
        check("async_rst busy", busy, 0);
        rst = 1'b0;
        req = 8'h04;
        n = 0;
        do begin
            step();
            n++;
        end while (!gnt_en && n < 5);
        check("grant2 gnt_en", gnt_en, 1);
        check("grant2 gnt_idx", gnt_idx, 2);
        check("grant2 latency", n, 1);

`ifdef TIMEOUT_EN
        n = 0;
        to_seen = 0;
        while (gnt_en && n < 40) begin
            if (timeout) to_seen++;
            n++;
            step();
        end
        check("tenure length", n, 16);
        check("tenure no early timeout", to_seen, 0);
        check("timeout pulse", timeout, 1);
        check("timeout gnt_en", gnt_en, 0);
        step();
        check("timeout one cycle", timeout, 0);
        step();
        check("regrant after timeout", {gnt_en, gnt_idx}, {1'b1, 3'd2});
        for (int i = 0; i < 15; i++) step();
        check("pre-expiry gnt_en", gnt_en, 1);
        rel = 1'b1;
        step();
        rel = 1'b0;
        check("rel at expiry gnt_en", gnt_en, 0);
        check("rel at expiry timeout", timeout, 0);
`else
        drops = 0;
        to_seen = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (!gnt_en) drops++;
            if (timeout) to_seen++;
        end
        check("long hold gnt_en drops", drops, 0);
        check("long hold timeout", to_seen, 0);
        check("long hold idx", gnt_idx, 2);
        rel = 1'b1;
        step();
        rel = 1'b0;
        check("long hold release gnt_en", gnt_en, 0);
        check("long hold release timeout", timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
